// File: rtl/csr_file_pkg.sv
// rtl/csr_file_pkg.sv - CSR addresses, FSM state encoding and counter width (CSR_CNTH_EN selects 64-bit counters)
package csr_file_pkg;

    localparam logic [11:0] CSR_TOHOST   = 12'h51E;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;

`ifdef CSR_CNTH_EN
    localparam int CNT_W = 64;
`else
    localparam int CNT_W = 32;
`endif

    typedef enum logic {
        CSR_ST_RUN  = 1'b0,
        CSR_ST_DONE = 1'b1
    } csr_state_e;

endpackage

// File: rtl/csr_counter.sv
// rtl/csr_counter.sv - free-running wrap-around event counter with enable
module csr_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: plain binary add, wraps to zero silently at the top.
    always_comb begin
        count_d = count_q;
        if (inc_en) begin
            count_d = count_q + W'(1);
        end
    end

    // Counter register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/csr_file.sv
// rtl/csr_file.sv - W-stage CSR file: tohost register, RUN/DONE test FSM, cycle/instret counters (CSR_CNTH_EN adds high halves)
module csr_file
    import csr_file_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            csr_we,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            instr_retire,
    output logic [XLEN-1:0] csr_rdata,
    output logic [XLEN-1:0] tohost,
    output logic            tohost_valid,
    output logic            done,
    output logic            pass
);

    csr_state_e      state_q, state_d;
    logic [XLEN-1:0] tohost_q, tohost_d;
    logic            tohost_valid_q, tohost_valid_d;
    logic            running;
    logic            wr_accept;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;

    assign running   = (state_q == CSR_ST_RUN);
    assign wr_accept = csr_we && !stall && running && (csr_addr == CSR_TOHOST);

    // Once DONE, everything freezes until reset; the cycle counter still ticks through stalls.
    csr_counter #(.W(CNT_W)) u_cycle (
        .clk    (clk),
        .rst    (rst),
        .inc_en (running),
        .count  (cycle_cnt)
    );

    csr_counter #(.W(CNT_W)) u_instret (
        .clk    (clk),
        .rst    (rst),
        .inc_en (instr_retire && !stall && running),
        .count  (instret_cnt)
    );

    // Next-state: an accepted tohost write latches data and pulses valid; non-zero data ends the test.
    always_comb begin
        state_d        = state_q;
        tohost_d       = tohost_q;
        tohost_valid_d = 1'b0;
        if (wr_accept) begin
            tohost_d       = csr_wdata;
            tohost_valid_d = 1'b1;
            if (csr_wdata != '0) begin
                state_d = CSR_ST_DONE;
            end
        end
    end

    // FSM and tohost registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= CSR_ST_RUN;
            tohost_q       <= '0;
            tohost_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            tohost_q       <= tohost_d;
            tohost_valid_q <= tohost_valid_d;
        end
    end

    // Read mux is purely combinational off registered state, so a same-cycle write reads the old value.
    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_TOHOST:   csr_rdata = tohost_q;
            CSR_CYCLE:    csr_rdata = XLEN'(cycle_cnt[31:0]);
            CSR_INSTRET:  csr_rdata = XLEN'(instret_cnt[31:0]);
`ifdef CSR_CNTH_EN
            CSR_CYCLEH:   csr_rdata = XLEN'(cycle_cnt[63:32]);
            CSR_INSTRETH: csr_rdata = XLEN'(instret_cnt[63:32]);
`endif
            default:      csr_rdata = '0;
        endcase
    end

    assign tohost       = tohost_q;
    assign tohost_valid = tohost_valid_q;
    assign done         = (state_q == CSR_ST_DONE);
    assign pass         = done && (tohost_q == XLEN'(1));

endmodule
